// File: rtl/flag_reg_unit.sv
// Condition-flag register: captures C/Z/N/V from ALU results or a context load,
// tracks sticky C/V events with a maskable IRQ and a saturating overflow-event counter.
module flag_reg_unit #(
    parameter int           WIDTH     = 8,
    parameter logic [7:0]   ARITH_OPS = 8'b0000_0011,
    parameter int           CNTW      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] Y,
    input  logic             arith_carry_borrow,
    input  logic             arith_overflow,
    input  logic [2:0]       op,
    input  logic             flag_we,
    input  logic             flags_load,
    input  logic [3:0]       flags_in,
    input  logic [1:0]       sticky_clr,
    input  logic [1:0]       irq_mask,
    output logic             carry_out,
    output logic             zero,
    output logic             sign,
    output logic             overflow,
    output logic [1:0]       sticky,
    output logic [CNTW-1:0]  ovf_count,
    output logic             irq
);

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    logic            c_nxt, z_nxt, n_nxt, v_nxt;
    logic            c_wr, v_wr;
    logic            c_set, v_set;
    logic [1:0]      sticky_nxt;
    logic [CNTW-1:0] cnt_nxt;

    // flags_load outranks flag_we; non-arithmetic ops leave C/V untouched.
    always_comb begin
        c_nxt = carry_out;
        z_nxt = zero;
        n_nxt = sign;
        v_nxt = overflow;
        c_wr  = 1'b0;
        v_wr  = 1'b0;
        if (flags_load) begin
            c_nxt = flags_in[3];
            z_nxt = flags_in[2];
            n_nxt = flags_in[1];
            v_nxt = flags_in[0];
            c_wr  = 1'b1;
            v_wr  = 1'b1;
        end else if (flag_we) begin
            z_nxt = (Y == '0);
            n_nxt = Y[WIDTH-1];
            if (ARITH_OPS[op]) begin
                c_nxt = arith_carry_borrow;
                v_nxt = arith_overflow;
                c_wr  = 1'b1;
                v_wr  = 1'b1;
            end
        end
    end

    // A new event beats a coincident clear so it is never lost.
    always_comb begin
        c_set         = c_wr & c_nxt;
        v_set         = v_wr & v_nxt;
        sticky_nxt[1] = c_set | (sticky[1] & ~sticky_clr[1]);
        sticky_nxt[0] = v_set | (sticky[0] & ~sticky_clr[0]);
        cnt_nxt       = ovf_count;
        if (v_set) begin
            if (ovf_count != CNT_MAX) begin
                cnt_nxt = ovf_count + 1'b1;
            end
        end else if (sticky_clr[0]) begin
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            carry_out <= 1'b0;
            zero      <= 1'b0;
            sign      <= 1'b0;
            overflow  <= 1'b0;
            sticky    <= 2'b00;
            ovf_count <= '0;
        end else begin
            carry_out <= c_nxt;
            zero      <= z_nxt;
            sign      <= n_nxt;
            overflow  <= v_nxt;
            sticky    <= sticky_nxt;
            ovf_count <= cnt_nxt;
        end
    end

    assign irq = |(sticky & irq_mask);

endmodule

// File: tb/tb_flag_reg_unit.sv
// Randomised and directed bench for flag_reg_unit (default instance plus a CNTW=2 instance).
module tb_flag_reg_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] Y;
    logic       carry, ovf;
    logic [2:0] op;
    logic       flag_we, flags_load;
    logic [3:0] flags_in;
    logic [1:0] sticky_clr, irq_mask;

    logic       a_c, a_z, a_n, a_v, a_irq;
    logic [1:0] a_sticky;
    logic [7:0] a_cnt;
    logic       b_c, b_z, b_n, b_v, b_irq;
    logic [1:0] b_sticky;
    logic [1:0] b_cnt;

    int errors = 0;
    int checks = 0;

    // reference state
    bit m_c, m_z, m_n, m_v, m_sc, m_sv;
    int m_cnt, m_cnt2;

    always #5 clk = ~clk;

    flag_reg_unit dut_a (
        .clk(clk), .rst(rst), .Y(Y), .arith_carry_borrow(carry), .arith_overflow(ovf),
        .op(op), .flag_we(flag_we), .flags_load(flags_load), .flags_in(flags_in),
        .sticky_clr(sticky_clr), .irq_mask(irq_mask),
        .carry_out(a_c), .zero(a_z), .sign(a_n), .overflow(a_v),
        .sticky(a_sticky), .ovf_count(a_cnt), .irq(a_irq)
    );

    flag_reg_unit #(.CNTW(2)) dut_b (
        .clk(clk), .rst(rst), .Y(Y), .arith_carry_borrow(carry), .arith_overflow(ovf),
        .op(op), .flag_we(flag_we), .flags_load(flags_load), .flags_in(flags_in),
        .sticky_clr(sticky_clr), .irq_mask(irq_mask),
        .carry_out(b_c), .zero(b_z), .sign(b_n), .overflow(b_v),
        .sticky(b_sticky), .ovf_count(b_cnt), .irq(b_irq)
    );

    wire [14:0] obs_a = {a_c, a_z, a_n, a_v, a_sticky, a_cnt, a_irq};
    wire [14:0] obs_b = {b_c, b_z, b_n, b_v, b_sticky, 6'd0, b_cnt, b_irq};

    function automatic logic [14:0] exp_a();
        logic [7:0] cnt8 = m_cnt[7:0];
        bit irq_e = (m_sc && irq_mask[1]) || (m_sv && irq_mask[0]);
        return {m_c, m_z, m_n, m_v, m_sc, m_sv, cnt8, irq_e};
    endfunction

    function automatic logic [14:0] exp_b();
        logic [1:0] cnt2 = m_cnt2[1:0];
        bit irq_e = (m_sc && irq_mask[1]) || (m_sv && irq_mask[0]);
        return {m_c, m_z, m_n, m_v, m_sc, m_sv, 6'd0, cnt2, irq_e};
    endfunction

    // Reference behaviour: ops 0 and 1 are arithmetic under the default op set.
    task automatic model_step();
        bit c_w = 0, v_w = 0;
        if (rst) begin
            {m_c, m_z, m_n, m_v, m_sc, m_sv} = '0;
            m_cnt = 0;
            m_cnt2 = 0;
            return;
        end
        if (flags_load) begin
            {m_c, m_z, m_n, m_v} = flags_in;
            c_w = 1;
            v_w = 1;
        end else if (flag_we) begin
            m_z = (Y == 0);
            m_n = (Y >= 8'h80);
            if (op < 2) begin
                m_c = carry;
                m_v = ovf;
                c_w = 1;
                v_w = 1;
            end
        end
        if (c_w && m_c) m_sc = 1;
        else if (sticky_clr[1]) m_sc = 0;
        if (v_w && m_v) begin
            m_sv = 1;
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end else if (sticky_clr[0]) begin
            m_sv = 0;
            m_cnt = 0;
            m_cnt2 = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; flag_we = 0; flags_load = 0; sticky_clr = 0;
    endtask

    task automatic test_reset();
        rst = 1; flag_we = 1; flags_load = 1; flags_in = 4'hF; Y = 8'h00;
        carry = 1; ovf = 1; op = 0; sticky_clr = 0; irq_mask = 2'b11;
        tick();
        checks++;
        if (obs_a !== 15'h0) begin
            errors++;
            $display("FAIL reset_a: got %h expected %h", obs_a, 15'h0);
        end
        checks++;
        if (obs_b !== 15'h0) begin
            errors++;
            $display("FAIL reset_b: got %h expected %h", obs_b, 15'h0);
        end
    endtask

    task automatic test_arith_capture();
        idle(); irq_mask = 0;
        op = 0; Y = 8'h00; carry = 1; ovf = 1; flag_we = 1;
        tick();
        checks++;
        if (obs_a !== 15'b1101_11_00000001_0) begin
            errors++;
            $display("FAIL arith_capture: got %b expected %b", obs_a, 15'b1101_11_00000001_0);
        end
        op = 5; Y = 8'h80; carry = 0; ovf = 0;
        tick();
        checks++;
        if (obs_a !== 15'b1011_11_00000001_0) begin
            errors++;
            $display("FAIL nonarith_hold: got %b expected %b", obs_a, 15'b1011_11_00000001_0);
        end
        idle(); Y = $urandom; op = 1; carry = 0; ovf = 0;
        tick();
        checks++;
        if (obs_a !== 15'b1011_11_00000001_0) begin
            errors++;
            $display("FAIL idle_hold: got %b expected %b", obs_a, 15'b1011_11_00000001_0);
        end
    endtask

    task automatic test_set_beats_clear();
        idle(); irq_mask = 0;
        op = 1; Y = 8'h03; carry = 0; ovf = 1; flag_we = 1; sticky_clr = 2'b01;
        tick();
        checks++;
        if (obs_a !== 15'b0001_11_00000010_0) begin
            errors++;
            $display("FAIL set_beats_clear: got %b expected %b", obs_a, 15'b0001_11_00000010_0);
        end
        idle(); sticky_clr = 2'b01; irq_mask = 2'b01;
        tick();
        checks++;
        if (obs_a !== 15'b0001_10_00000000_0) begin
            errors++;
            $display("FAIL clear_v: got %b expected %b", obs_a, 15'b0001_10_00000000_0);
        end
        idle(); irq_mask = 2'b10;
        #1;
        checks++;
        if (a_irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_c_mask: got %b expected 1", a_irq);
        end
    endtask

    task automatic test_saturate();
        int want2 [5] = '{1, 2, 3, 3, 3};
        idle(); rst = 1;
        tick();
        idle(); op = 0; Y = 8'h11; carry = 0; ovf = 1; flag_we = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (b_cnt !== want2[i][1:0]) begin
                errors++;
                $display("FAIL saturate_%0d: got %0d expected %0d", i, b_cnt, want2[i]);
            end
            checks++;
            if (a_cnt !== 8'(i + 1)) begin
                errors++;
                $display("FAIL count8_%0d: got %0d expected %0d", i, a_cnt, i + 1);
            end
        end
    endtask

    task automatic test_load_priority();
        for (int m = 0; m < 4; m++) begin
            idle(); rst = 1;
            tick();
            idle(); irq_mask = 2'(m);
            flags_load = 1; flags_in = 4'b1001; flag_we = 1; Y = 8'h00; op = 0;
            carry = 0; ovf = 0;
            tick();
            checks++;
            if ({a_c, a_z, a_n, a_v, a_irq} !== {4'b1001, m != 0}) begin
                errors++;
                $display("FAIL load_priority_m%0d: got %b expected %b", m,
                         {a_c, a_z, a_n, a_v, a_irq}, {4'b1001, m != 0});
            end
        end
    endtask

    task automatic test_reset_priority();
        idle(); irq_mask = 2'b11;
        rst = 1; flag_we = 1; op = 0; Y = 8'h00; carry = 1; ovf = 1;
        tick();
        checks++;
        if ({obs_a, obs_b} !== 30'h0) begin
            errors++;
            $display("FAIL reset_priority: got %h/%h expected 0", obs_a, obs_b);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 49) == 0);
            Y          = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            carry      = 1'($urandom);
            ovf        = 1'($urandom);
            op         = 3'($urandom);
            flag_we    = 1'($urandom);
            flags_load = ($urandom_range(0, 7) == 0);
            flags_in   = 4'($urandom);
            sticky_clr = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00;
            irq_mask   = 2'($urandom);
            tick();
            checks++;
            if (obs_a !== exp_a()) begin
                errors++;
                $display("FAIL random_a_%0d: got %b expected %b", i, obs_a, exp_a());
            end
            checks++;
            if (obs_b !== exp_b()) begin
                errors++;
                $display("FAIL random_b_%0d: got %b expected %b", i, obs_b, exp_b());
            end
        end
    endtask

    initial begin
        rst = 1; Y = 0; carry = 0; ovf = 0; op = 0; flag_we = 0; flags_load = 0;
        flags_in = 0; sticky_clr = 0; irq_mask = 0;
        @(negedge clk);
        tick();
        test_reset();
        test_arith_capture();
        test_set_beats_clear();
        test_saturate();
        test_load_priority();
        test_reset_priority();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
